// File: rtl/msg_serializer_pkg.sv
// Shared types and constants for the msg_serializer slice.
// Defining PARITY_EN adds the PARITY state to the encoding.
package msg_serializer_pkg;

  localparam int unsigned DEF_MSG_W = 5;
  localparam logic        IDLE_LVL  = 1'b1;

`ifdef PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} ser_state_e;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} ser_state_e;
`endif

endpackage

// File: rtl/msg_bit_cnt.sv
// Tick-qualified up-counter with synchronous clear, enable and a
// terminal-count flag; it holds at LAST rather than wrapping.
module msg_bit_cnt
  import msg_serializer_pkg::*;
#(
  parameter int unsigned W    = 1,
  parameter int unsigned LAST = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic tick,
  output logic tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && tick && !tc) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == W'(LAST));

endmodule

// File: rtl/msg_serializer.sv
// Tick-paced parallel-to-serial transmitter: start bit, data LSB first,
// optional even parity (PARITY_EN), STOP_BITS stop bits; idle line high.
module msg_serializer
  import msg_serializer_pkg::*;
#(
  parameter int unsigned MSG_W     = DEF_MSG_W,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic [MSG_W-1:0] msg,
  output logic             tx_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BW = (MSG_W > 1) ? $clog2(MSG_W) : 1;

  ser_state_e       state, state_nxt;
  logic [MSG_W-1:0] shreg;
  logic             accept;
  logic             bit_tc;
  logic             stop_tc;
  logic             cnt_clr;
`ifdef PARITY_EN
  logic             par;
`endif

  assign accept  = (state == IDLE) && start;
  assign cnt_clr = (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
`ifdef PARITY_EN
      par   <= 1'b0;
`endif
    end else if (accept) begin
      shreg <= msg;
`ifdef PARITY_EN
      par   <= ^msg;
`endif
    end else if ((state == DATA) && tick) begin
      shreg <= {IDLE_LVL, shreg[MSG_W-1:1]};
    end
  end

  msg_bit_cnt #(
    .W    (BW),
    .LAST (MSG_W - 1)
  ) u_bit_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (state == DATA),
    .tick (tick),
    .tc   (bit_tc)
  );

  msg_bit_cnt #(
    .W    (1),
    .LAST (STOP_BITS - 1)
  ) u_stop_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (state == STOP),
    .tick (tick),
    .tc   (stop_tc)
  );

  // Only IDLE->START ignores tick; every other move waits for the strobe.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = START;
      START:  if (tick) state_nxt = DATA;
`ifdef PARITY_EN
      DATA:   if (tick && bit_tc) state_nxt = PARITY;
      PARITY: if (tick) state_nxt = STOP;
`else
      DATA:   if (tick && bit_tc) state_nxt = STOP;
`endif
      STOP:   if (tick && stop_tc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // done is raised during the last STOP cycle so a start there is still
  // seen in STOP and dropped; busy falls as the state lands in IDLE.
  always_comb begin
    tx_out = IDLE_LVL;
    busy   = 1'b1;
    done   = 1'b0;
    case (state)
      IDLE:   busy = 1'b0;
      START:  tx_out = ~IDLE_LVL;
      DATA:   tx_out = shreg[0];
`ifdef PARITY_EN
      PARITY: tx_out = par;
`endif
      STOP:   done = tick && stop_tc;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: doc/msg_serializer.md
Name: msg_serializer

Overview:
Parallel-to-serial transmitter that consumes the divided-rate strobe produced by the frequency-divider stage and shifts a 5-bit message out one bit per strobe.
- Frame format: start bit, data LSB first, optional parity, stop bits.
- Sits directly downstream of the divider/select stage; its `tick` input is that stage's output.
- Idle line level is high.

Parameters:
- MSG_W, 5, message width in bits.
- STOP_BITS, 1, number of stop-bit periods (1 or 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- tick  input  1  bit-rate strobe from the divider, one clk cycle wide.
- start  input  1  request to send; sampled only in IDLE.
- msg  input  MSG_W  message; captured on accepted start.
- tx_out  output  1  serial line.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; tx_out=1, busy=0, done=0.
  - Shift register and counters cleared.
  - Applies immediately mid-frame, and the frame is abandoned.
- FSM states: IDLE, START, DATA, PARITY (only with PARITY_EN), STOP.
- IDLE:
  - tx_out=1, busy=0.
  - start=1 at a clk edge → latch msg into shift register, bit_cnt=0, go to START.
  - busy=1 and tx_out=0 from the next cycle.
- START: tx_out=0; on tick → DATA.
- DATA:
  - tx_out=shreg[0].
  - On tick: shift right, bit_cnt+1.
  - When bit_cnt==MSG_W-1 and tick → PARITY if enabled, else STOP.
- PARITY: tx_out=parity bit; on tick → STOP.
- STOP:
  - tx_out=1; stop_cnt counts ticks.
  - On the STOP_BITS-th tick → IDLE, done=1 for exactly that one cycle, busy=0 the same cycle the state returns to IDLE.
- State changes only on tick, except the IDLE→START transition.
- The first (start) bit lasts from acceptance until the first tick. Its duration is therefore 1..N clk cycles, where N is the tick period. All later bits last exactly one tick period.
- Boundary conditions:
  - start while busy: ignored, no queuing, msg not re-latched.
  - start and tick in the same cycle in IDLE: start accepted; that tick does not advance START.
  - msg changing mid-frame: no effect; the latched copy is used.
  - tick absent: FSM holds its state indefinitely.
  - done and start in the same cycle: start is not accepted; state is still STOP at the sampling edge. A new frame may begin the cycle after done.
  - tick held high continuously: one bit per clk cycle, legal.
- Counter widths:
  - bit_cnt: clog2(MSG_W) bits, no wrap beyond MSG_W-1.
  - stop_cnt: 1 bit.

Optional Feature:
- Macro PARITY_EN.
- Defined: PARITY state inserted after DATA; tx_out = XOR of the latched msg (even parity).
- Undefined: DATA goes directly to STOP; the parity logic and state encoding are absent.

Decomposition:
- Shared package holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - default MSG_W constant;
  - idle line level constant (1).
- One natural sub-module: msg_bit_cnt. It is a tick-qualified counter with clear, enable and terminal-count flag, and is used for both bit_cnt and stop_cnt.

Test Plan:
- Reset mid-frame: pull rst low during DATA → same cycle tx_out=1, busy=0; after release, frame is not resumed.
- Basic frame: tick every 4 clk, msg=5'b10110, start pulse → tx_out sequence per tick 0 | 0,1,1,0,1 | 1. done pulses once; busy high across 7 bit periods.
- Parity (PARITY_EN defined): same msg → 0 | 0,1,1,0,1 | 1 (parity, three ones) | 1.
- Busy rejection: start=1 with msg=5'b11111 while mid-frame → output still matches the original msg; no second frame follows.
- Simultaneous start+tick in IDLE: tx_out=0 persists through one full tick period after the coincident tick. With STOP_BITS=2, stop level lasts 2 ticks before done.
- Back-to-back frames: start asserted in the cycle after done → second frame begins, with no extra idle period beyond that cycle.
